// File: rtl/nibble_pkg.sv
// Shared types for the nibble front end and the 4-bit inverter datapath.
package nibble_pkg;

  localparam int NIBBLE_W = 4;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  // Output holding register occupancy.
  typedef enum logic {EMPTY, FULL} ostate_e;

endpackage

// File: rtl/nibble_deser_sipo_shift.sv
// Serial-in parallel-out shifter: collects bits LSB first and strobes
// word_done in the same cycle that the last bit of a word is presented, so the
// caller can capture the completed word at that edge.
module sipo_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             word_done,
  output logic [WIDTH-1:0] word
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;

  // New bits enter at the top and move down, so the first bit ends in bit 0.
  assign word      = {sin, sr[WIDTH-1:1]};
  assign word_done = sin_valid && (cnt == LAST);

  // Shift in accepted bits and count them, wrapping at the end of each word.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values and simulation ordering cannot change the result.
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (sin_valid) begin
      sr  <= word;
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/nibble_deser.sv
// Serial-to-parallel front end: assembles WIDTH-bit words (WIDTH >= 2) from a
// serial line and presents them through one registered valid/ready holding
// register. Words completing while the register is full and not draining are
// dropped and recorded in the sticky overrun flag.
module nibble_deser
  import nibble_pkg::*;
#(
  parameter int WIDTH = NIBBLE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             clear_overrun
);

  ostate_e          state;
  ostate_e          state_nx;
  logic             word_done;
  logic [WIDTH-1:0] word;
  logic             xfer;
  logic             load;
  logic             drop;

  sipo_shift #(.WIDTH(WIDTH)) u_sipo (
    .clk       (clk),
    .reset     (reset),
    .sin       (sin),
    .sin_valid (sin_valid),
    .word_done (word_done),
    .word      (word)
  );

  // dout_valid comes straight from the state flop, so it is registered.
  assign dout_valid = (state == FULL);
  assign xfer       = dout_valid && dout_ready;
  // A completing word may replace the held one only if that one leaves now.
  assign load       = word_done && (!dout_valid || xfer);
  assign drop       = word_done && dout_valid && !dout_ready;

  // Next occupancy of the holding register.
  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch forms.
    state_nx = state;
    case (state)
      EMPTY: if (word_done)          state_nx = FULL;
      FULL:  if (xfer && !word_done) state_nx = EMPTY;
    endcase
  end

  // Holding register, occupancy state and sticky overrun (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      dout    <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) dout <= word;
      if (drop)               overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nibble_deser.sv
// Scoreboard bench for nibble_deser: a word-level reference model pushes
// expected words, a negedge monitor compares and pops on each transfer.
module tb_nibble_deser;
  import nibble_pkg::*;

  logic    clk = 1'b0;
  logic    reset = 1'b0;
  logic    sin = 1'b0;
  logic    sin_valid = 1'b0;
  nibble_t dout;
  logic    dout_valid;
  logic    dout_ready = 1'b0;
  logic    overrun;
  logic    clear_overrun = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  bit done     = 1'b0;

  // Reference model state.
  int      bits_q[$];     // bits of the word being assembled, first bit first
  nibble_t exp_q[$];      // words expected to appear on dout, in order
  bit      m_held = 1'b0; // a word is held for downstream
  bit      m_ovr  = 1'b0;

  nibble_deser #(.WIDTH(NIBBLE_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .sin           (sin),
    .sin_valid     (sin_valid),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: advances on each rising edge from the inputs alone.
  always @(posedge clk) begin
    if (reset) begin
      bits_q.delete();
      exp_q.delete();
      m_held = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      bit taken;
      bit set_ovr;
      taken   = m_held && dout_ready;
      set_ovr = 1'b0;
      if (taken) m_held = 1'b0;
      if (sin_valid) begin
        bits_q.push_back(int'(sin));
        if (bits_q.size() == NIBBLE_W) begin
          int w;
          w = 0;
          for (int i = 0; i < NIBBLE_W; i++) w += bits_q[i] * (1 << i);
          bits_q.delete();
          if (!m_held) begin
            exp_q.push_back(nibble_t'(w));
            m_held = 1'b1;
          end else begin
            set_ovr = 1'b1;
          end
        end
      end
      if (set_ovr)            m_ovr = 1'b1;
      else if (clear_overrun) m_ovr = 1'b0;
    end
  end

  // Monitor: compare outputs mid-cycle; pop when the next edge transfers.
  always @(negedge clk) begin
    if (!done) begin
      check("dout_valid", 32'(dout_valid), 32'(m_held));
      check("overrun", 32'(overrun), 32'(m_ovr));
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          check("dout_unexpected", 32'(dout), 32'hFFFF_FFFF);
        end else begin
          check("dout", 32'(dout), 32'(exp_q[0]));
          if (dout_ready && !reset) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Apply one cycle of inputs, then return just after the edge.
  task automatic drive(input logic r, input logic sv, input logic s,
                       input logic rdy, input logic clr);
    reset         = r;
    sin_valid     = sv;
    sin           = s;
    dout_ready    = rdy;
    clear_overrun = clr;
    @(posedge clk);
    #1;
  endtask

  // Send a word LSB first; ready applies to all bits, last_ready to the last.
  task automatic send_word(input logic [3:0] w, input logic rdy,
                           input logic last_rdy, input logic last_clr);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, w[i], rdy, 1'b0);
    drive(1'b0, 1'b1, w[3], last_rdy, last_clr);
  endtask

  task automatic idle(input int n, input logic rdy, input logic clr);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, rdy, clr);
  endtask

  initial begin
    // Reset with random serial activity.
    for (int i = 0; i < 2; i++)
      drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_valid", 32'(dout_valid), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);

    // Partial word lost across reset.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(4'hD, 1'b0, 1'b0, 1'b0);
    check("reset_partial_dout", 32'(dout), 32'hD);
    idle(1, 1'b1, 1'b0);

    // Basic assembly, back to back with ready high.
    send_word(4'hD, 1'b1, 1'b1, 1'b0);
    check("basic_D", 32'(dout), 32'hD);
    send_word(4'hE, 1'b1, 1'b1, 1'b0);
    send_word(4'h8, 1'b1, 1'b1, 1'b0);
    check("basic_8", 32'(dout), 32'h8);
    idle(2, 1'b1, 1'b0);

    // Gaps between bits.
    for (int i = 0; i < 4; i++) begin
      logic [3:0] w3 = 4'h3;
      drive(1'b0, 1'b1, w3[i], 1'b1, 1'b0);
      if (i < 3) idle(3, 1'b1, 1'b0);
    end
    check("gap_3", 32'(dout), 32'h3);
    idle(1, 1'b1, 1'b0);

    // Backpressure: hold, then one-cycle drain.
    send_word(4'hA, 1'b0, 1'b0, 1'b0);
    idle(10, 1'b0, 1'b0);
    check("hold_A", 32'(dout), 32'hA);
    idle(1, 1'b1, 1'b0);
    check("drain_valid", 32'(dout_valid), 32'h0);

    // Overrun, clear, and set-beats-clear.
    send_word(4'h5, 1'b0, 1'b0, 1'b0);
    send_word(4'hF, 1'b0, 1'b0, 1'b0);
    check("ovr_dout", 32'(dout), 32'h5);
    check("ovr_set", 32'(overrun), 32'h1);
    idle(1, 1'b0, 1'b1);
    check("ovr_clear", 32'(overrun), 32'h0);
    send_word(4'h6, 1'b0, 1'b0, 1'b1);
    check("ovr_set_wins", 32'(overrun), 32'h1);
    idle(1, 1'b0, 1'b1);

    // Drain and complete on the same edge.
    send_word(4'h9, 1'b0, 1'b1, 1'b0);
    check("simul_dout", 32'(dout), 32'h9);
    check("simul_valid", 32'(dout_valid), 32'h1);
    check("simul_overrun", 32'(overrun), 32'h0);
    idle(2, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      drive(1'($urandom_range(99) == 0), 1'($urandom_range(9) < 7),
            1'($urandom), 1'($urandom_range(1)), 1'($urandom_range(19) == 0));
    idle(3, 1'b1, 1'b0);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nibble_deser.md
# nibble_deser

Serial-to-parallel front end for the 4-bit inverter datapath. It collects single bits from a serial line, LSB first, into a WIDTH-bit word and presents the word on a registered valid/ready output. That output drives the inverter's 4-bit input bus `a`. One output holding register decouples serial arrival from downstream acceptance, and a sticky flag records dropped words.

## Interface
- `WIDTH`, default 4: bits per word; must be ≥2. Set to 4 in this design.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `sin` input 1: serial data bit.
- `sin_valid` input 1: `sin` is sampled at this edge. There is no backpressure on the serial side.
- `dout` output WIDTH: assembled word; bit 0 is the first bit received.
- `dout_valid` output 1: `dout` holds an unconsumed word.
- `dout_ready` input 1: downstream accepts `dout` at this edge when `dout_valid` is 1.
- `overrun` output 1: sticky; a completed word was dropped.
- `clear_overrun` input 1: clears `overrun` at this edge.

## Operation
- Internal state:
  - shift register `sr[WIDTH-1:0]`;
  - bit counter `cnt`, range 0..WIDTH-1, width $clog2(WIDTH);
  - output register `dout` with flag `dout_valid`.
- Accepting a bit (`sin_valid`=1): `sr <= {sin, sr[WIDTH-1:1]}`. After WIDTH accepted bits, the first bit sits in `sr[0]`.
- `cnt` increments on each accepted bit. When an accepted bit finds `cnt`==WIDTH-1, the word completes and `cnt` wraps to 0.
- `sin_valid`=0 leaves `sr` and `cnt` unchanged. Gaps of any length between bits are legal.
- Output-side transfer occurs when `dout_valid`&&`dout_ready` at an edge.
- On word completion, the completed word is `{sin, sr[WIDTH-1:1]}`:
  - If `dout_valid`=0, or a transfer occurs at the same edge: `dout` loads the completed word and `dout_valid` is 1 next cycle.
  - Otherwise: the completed word is discarded, `dout`/`dout_valid` are unchanged, and `overrun` is set.
- A transfer with no completion at the same edge makes `dout_valid` 0 next cycle. `dout` keeps its last value; it is don't-care when `dout_valid` is 0.
- `overrun`:
  - set has priority over `clear_overrun` at the same edge;
  - otherwise it is cleared by `clear_overrun`;
  - it never clears on its own.
- State machine, two states:
  - `EMPTY` (`dout_valid`=0): → `FULL` on completion.
  - `FULL` (`dout_valid`=1): → `EMPTY` on transfer without completion; stays `FULL` on completion, whether with a transfer (reload) or without one (overrun).
  - `cnt` is independent of the state.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Reset values: `dout`=0, `dout_valid`=0, `overrun`=0, `cnt`=0, `sr`=0, state `EMPTY`.
- Latency: the WIDTH-th bit accepted at edge N gives `dout_valid`=1 and the new `dout` in the cycle after edge N.
- Throughput: one word per WIDTH cycles of continuous `sin_valid`, provided `dout_ready` is held high.
- `dout` and `dout_valid` must be stable while `dout_valid`=1 and `dout_ready`=0.
- `dout_ready` may be asserted while `dout_valid`=0. It has no effect.
- `reset` mid-word discards any partial word (`cnt`→0) and any held word. `reset` wins over all other inputs at the same edge.

## Structure
- Shared package `nibble_pkg`:
  - `localparam int NIBBLE_W = 4`;
  - `typedef logic [NIBBLE_W-1:0] nibble_t`;
  - `typedef enum logic {EMPTY, FULL} ostate_e`.
- One natural sub-module, `sipo_shift`: holds `sr` and `cnt`, and emits a one-cycle `word_done` strobe plus `word`.
- The top level holds the output register, the state machine and the `overrun` logic.
- Instantiated directly ahead of the inverter, with `dout` wired to `a`.

## Test plan
- **Reset:** hold `reset` 2 cycles with random `sin`/`sin_valid` → `dout`=0, `dout_valid`=0, `overrun`=0. After release, 3 bits then `reset`, then bits 1,0,1,1 → `dout`=4'hD; the partial word is lost.
- **Basic assembly:** `dout_ready`=1; bits 1,0,1,1 on consecutive cycles → `dout`=4'hD, `dout_valid`=1 for exactly one cycle, one cycle after the 4th bit. Bits 0,1,1,1 then 0,0,0,1 back-to-back → 4'hE then 4'h8.
- **Gaps:** bits 1,1,0,0 with `sin_valid` low 3 cycles between each → `dout`=4'h3; `dout_valid` only after the 4th bit.
- **Backpressure:** `dout_ready`=0; send 4'hA (bits 0,1,0,1) → `dout` stable at 4'hA for 10 cycles. Raise `dout_ready` for 1 cycle → `dout_valid` drops next cycle.
- **Overrun:** `dout_ready`=0; send 4'h5 then 4'hF → `dout` stays 4'h5 and `overrun`=1. Pulse `clear_overrun` → `overrun`=0. Pulse `clear_overrun` on the same edge as another drop → `overrun` stays 1.
- **Simultaneous drain and complete:** `dout`=4'h5 held; assert `dout_ready` on the edge where the 4th bit of 4'h9 arrives → `dout`=4'h9, `dout_valid` stays 1, `overrun` stays 0.
